// File: rtl/pixel_stage_sequencer.sv
// rtl/pixel_stage_sequencer.sv - sequences chained pixel engines, serves their SDRAM pixel reads, retries failed frames
module pixel_stage_sequencer #(
    parameter int N_STAGE   = 4,
    parameter int COORD_W   = 10,
    parameter int ADDR_W    = 24,
    parameter int DATA_W    = 16,
    parameter int IMG_W     = 640,
    parameter int ADDR_OFS  = 4,
    parameter int THRESH    = 400,
    parameter int TMO_W     = 20,
    parameter int MAX_RETRY = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         frame_start,
    output logic [N_STAGE-1:0]           stg_start,
    input  logic [N_STAGE-1:0]           stg_req,
    input  logic [N_STAGE*COORD_W-1:0]   stg_x,
    input  logic [N_STAGE*COORD_W-1:0]   stg_y,
    input  logic [N_STAGE-1:0]           stg_done,
    input  logic [N_STAGE-1:0]           stg_err,
    output logic [N_STAGE-1:0]           pix_valid,
    output logic                         pix_bit,
    output logic                         rd_burst_req,
    output logic [ADDR_W-1:0]            rd_burst_addr,
    input  logic [DATA_W-1:0]            rd_burst_data,
    input  logic                         rd_burst_data_valid,
    input  logic                         rd_burst_finish,
    output logic                         busy,
    output logic                         frame_done,
    output logic                         frame_err,
    output logic [2:0]                   err_stage,
    output logic [1:0]                   retry_cnt
);

    localparam int IDX_W = (N_STAGE > 1) ? $clog2(N_STAGE) : 1;
    localparam logic [DATA_W-1:0] THRESH_V = DATA_W'(THRESH);
    localparam logic [TMO_W-1:0]  WDOG_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_LAUNCH, S_RUN, S_READ, S_ADV, S_DONE, S_FAIL
    } state_t;

    state_t               state_q;
    logic [IDX_W-1:0]     idx_q;
    logic [TMO_W-1:0]     wdog_q;
    logic                 pend_q;
    logic [1:0]           retry_q;
    logic [2:0]           err_stage_q;
    logic [N_STAGE-1:0]   stg_start_q;
    logic [N_STAGE-1:0]   pix_valid_q;
    logic                 pix_bit_q;
    logic                 req_q;
    logic [ADDR_W-1:0]    addr_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 err_q;

    logic [COORD_W-1:0]   cur_x;
    logic [COORD_W-1:0]   cur_y;
    logic [ADDR_W-1:0]    addr_d;
    logic                 wdog_exp;
    logic                 fault;
    logic                 retry_ok;
    logic                 last_stage;

    function automatic logic [N_STAGE-1:0] onehot(input logic [IDX_W-1:0] i);
        return {{(N_STAGE-1){1'b0}}, 1'b1} << i;
    endfunction

    assign cur_x      = stg_x[idx_q*COORD_W +: COORD_W];
    assign cur_y      = stg_y[idx_q*COORD_W +: COORD_W];
    assign addr_d     = ADDR_W'(cur_y) * ADDR_W'(IMG_W) + ADDR_W'(cur_x) + ADDR_W'(ADDR_OFS);
    assign wdog_exp   = (wdog_q == WDOG_MAX);
    // pend_q carries an error or timeout seen mid-burst into the following RUN cycle
    assign fault      = stg_err[idx_q] | pend_q | wdog_exp;
    assign retry_ok   = (int'(retry_q) < MAX_RETRY);
    assign last_stage = (idx_q == IDX_W'(N_STAGE - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            wdog_q      <= '0;
            pend_q      <= 1'b0;
            retry_q     <= '0;
            err_stage_q <= '0;
            stg_start_q <= '0;
            pix_valid_q <= '0;
            pix_bit_q   <= 1'b0;
            req_q       <= 1'b0;
            addr_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            stg_start_q <= '0;
            pix_valid_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            if (rd_burst_data_valid) begin
                pix_bit_q <= (rd_burst_data < THRESH_V);
            end
            case (state_q)
                S_IDLE: begin
                    if (frame_start) begin
                        retry_q     <= '0;
                        err_stage_q <= '0;
                        pend_q      <= 1'b0;
                        idx_q       <= '0;
                        stg_start_q <= onehot('0);
                        busy_q      <= 1'b1;
                        state_q     <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    wdog_q  <= '0;
                    state_q <= S_RUN;
                end
                S_RUN: begin
                    wdog_q <= wdog_q + 1'b1;
                    if (fault) begin
                        pend_q <= 1'b0;
                        if (retry_ok) begin
                            retry_q     <= retry_q + 2'd1;
                            idx_q       <= '0;
                            stg_start_q <= onehot('0);
                            state_q     <= S_LAUNCH;
                        end else begin
                            err_q       <= 1'b1;
                            err_stage_q <= 3'(idx_q);
                            state_q     <= S_FAIL;
                        end
                    end else if (stg_done[idx_q]) begin
                        state_q <= S_ADV;
                    end else if (stg_req[idx_q]) begin
                        addr_q  <= addr_d;
                        req_q   <= 1'b1;
                        state_q <= S_READ;
                    end
                end
                S_READ: begin
                    if (stg_err[idx_q] || wdog_exp) begin
                        pend_q <= 1'b1;
                    end
                    if (rd_burst_finish) begin
                        req_q       <= 1'b0;
                        wdog_q      <= '0;
                        pix_valid_q <= onehot(idx_q);
                        state_q     <= S_RUN;
                    end else if (!wdog_exp) begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                S_ADV: begin
                    if (last_stage) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        idx_q       <= idx_q + 1'b1;
                        stg_start_q <= onehot(idx_q + 1'b1);
                        state_q     <= S_LAUNCH;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign stg_start     = stg_start_q;
    assign pix_valid     = pix_valid_q;
    assign pix_bit       = pix_bit_q;
    assign rd_burst_req  = req_q;
    assign rd_burst_addr = addr_q;
    assign busy          = busy_q;
    assign frame_done    = done_q;
    assign frame_err     = err_q;
    assign err_stage     = err_stage_q;
    assign retry_cnt     = retry_q;

endmodule

// File: doc/pixel_stage_sequencer.md
PIXEL_STAGE_SEQUENCER -- requirements
Module: pixel_stage_sequencer

Interface
REQ-001 SHALL have parameter N_STAGE, default 4: number of chained search/decode engines, 2..8.
REQ-002 SHALL have parameter COORD_W, default 10: width of each engine's x and y coordinate.
REQ-003 SHALL have parameter ADDR_W, default 24: SDRAM address width.
REQ-004 SHALL have parameter DATA_W, default 16: SDRAM read data width.
REQ-005 SHALL have parameter IMG_W, default 640: line pitch in words.
REQ-006 SHALL have parameters ADDR_OFS, default 4, and THRESH, default 400: address offset and pixel binarisation threshold.
REQ-007 SHALL have parameters TMO_W, default 20, and MAX_RETRY, default 2: watchdog width and frame retry limit.
REQ-008 SHALL have port clk, input, 1: sole clock, all logic on its rising edge.
REQ-009 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-010 SHALL have port frame_start, input, 1: level request to process one frame.
REQ-011 SHALL have port stg_start, output, N_STAGE: one-hot start pulse per engine.
REQ-012 SHALL have port stg_req, input, N_STAGE: per-engine pixel request, level.
REQ-013 SHALL have ports stg_x and stg_y, input, N_STAGE*COORD_W: packed per-engine coordinates, engine k in bits [k*COORD_W +: COORD_W].
REQ-014 SHALL have ports stg_done and stg_err, input, N_STAGE: per-engine completion and failure pulses.
REQ-015 SHALL have port pix_valid, output, N_STAGE: one-hot pixel-ready pulse.
REQ-016 SHALL have port pix_bit, output, 1: binarised pixel, 1 = dark.
REQ-017 SHALL have port rd_burst_req, output, 1: SDRAM read request.
REQ-018 SHALL have port rd_burst_addr, output, ADDR_W: SDRAM read address.
REQ-019 SHALL have ports rd_burst_data, input, DATA_W, and rd_burst_data_valid, input, 1: SDRAM read data and its qualifier.
REQ-020 SHALL have port rd_burst_finish, input, 1: SDRAM read completion pulse.
REQ-021 SHALL have ports busy, frame_done, frame_err, all output, 1: status outputs.
REQ-022 SHALL have ports err_stage, output, 3, and retry_cnt, output, 2: failing-engine index and retries used.

Function
REQ-023 SHALL implement states IDLE, LAUNCH, RUN, READ, ADV, DONE, FAIL, with a stage index idx that resets to 0.
REQ-024 In IDLE with frame_start=1, the block SHALL clear retry_cnt, set idx=0 and go to LAUNCH; busy SHALL be 0 only in IDLE.
REQ-025 LAUNCH SHALL drive stg_start[idx]=1 for exactly one cycle, clear the watchdog and go to RUN.
REQ-026 In RUN, priority SHALL be stg_err[idx] or watchdog expiry, then stg_done[idx], then stg_req[idx].
REQ-027 On stg_done[idx] in RUN, the block SHALL go to ADV; ADV SHALL go to DONE if idx==N_STAGE-1, else increment idx and go to LAUNCH.
REQ-028 On stg_req[idx] in RUN, the block SHALL register rd_burst_addr = (y*IMG_W + x + ADDR_OFS) mod 2^ADDR_W using engine idx coordinates and go to READ.
REQ-029 In READ, rd_burst_req SHALL be held at 1 until and including the cycle rd_burst_finish=1; rd_burst_req SHALL be 0 in every other state.
REQ-030 On each rd_burst_data_valid, pix_bit SHALL load 1 if rd_burst_data < THRESH, else 0; otherwise pix_bit SHALL hold.
REQ-031 The cycle after rd_burst_finish, pix_valid[idx] SHALL be 1 for one cycle, carrying the pix_bit from the last data beat, and the state SHALL return to RUN.
REQ-032 The watchdog SHALL count cycles in RUN and READ, clear on LAUNCH and on each finish, and expire at 2^TMO_W-1.
REQ-033 On error or expiry, if retry_cnt < MAX_RETRY the block SHALL increment retry_cnt, set idx=0 and go to LAUNCH; otherwise it SHALL go to FAIL.
REQ-034 An error or timeout occurring during READ SHALL be acted on only after rd_burst_finish, so that no SDRAM burst is abandoned.
REQ-035 DONE SHALL pulse frame_done for one cycle; FAIL SHALL pulse frame_err for one cycle and latch err_stage=idx; both SHALL then go to IDLE.
REQ-036 stg_done, stg_err and stg_req from engines other than idx SHALL be ignored, and frame_start SHALL be ignored while busy.
REQ-037 err_stage and retry_cnt SHALL hold until the next accepted frame_start.

Reset
REQ-038 reset=0 SHALL asynchronously force state IDLE, idx=0, and all outputs to 0 (rd_burst_addr=0, pix_bit=0, busy=0).
REQ-039 Reset mid-READ SHALL drop rd_burst_req immediately, and no pix_valid SHALL follow release.

Verification
REQ-040 Bench SHALL cover nominal flow: with N_STAGE=4, each engine issues 1 request at x=3,y=2, data=100 -> addr=1287, pix_bit=1, pix_valid one-hot per engine, and frame_done pulse after engine 3 done.
REQ-041 Bench SHALL cover threshold boundary: data=399 -> pix_bit=1; data=400 -> pix_bit=0.
REQ-042 Bench SHALL cover retry: engine 2 asserts stg_err once -> retry_cnt=1, stg_start[0] re-pulsed, and frame completes with frame_done.
REQ-043 Bench SHALL cover failure: engine 1 errors 3 times with MAX_RETRY=2 -> frame_err pulse, err_stage=1, retry_cnt=2.
REQ-044 Bench SHALL cover watchdog: with TMO_W=4 and engine silent -> retry after 15 cycles, and stg_err asserted during READ is deferred until finish.
REQ-045 Bench SHALL cover simultaneous events and reset: stg_done and stg_req in the same cycle -> ADV with no read; reset asserted mid-READ -> all outputs 0 at once.
